// File: rtl/id_ex_pkg.sv
// Shared ID/EX definitions: skid-buffer states and ALU opcodes.
// Used by id_ex_stage, id_ex_fwd_mux and the ALU.
package id_ex_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_LUI = 4'b1000;
   localparam logic [3:0] ALU_ORI = 4'b1001;

endpackage

// File: rtl/id_ex_fwd_mux.sv
// Write-back forwarding select for one operand.
// Register x0 and unused source operands never forward.
module id_ex_fwd_mux
   import id_ex_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  wb_we,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic [DATA_WIDTH-1:0] wb_data,
   input  logic [REG_ADDR_W-1:0] rs,
   input  logic                  use_rs,
   input  logic [DATA_WIDTH-1:0] operand,
   output logic [DATA_WIDTH-1:0] result
);

   logic hit;

   assign hit    = wb_we && use_rs && (wb_rd != '0) && (wb_rd == rs);
   assign result = hit ? wb_data : operand;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register as a two-entry skid buffer (main + skid).
// Define FORWARDING_EN to patch held/incoming operands from write-back.
module id_ex_stage
   import id_ex_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [3:0]            ALU_Operation_i,
   input  logic [DATA_WIDTH-1:0] A_i,
   input  logic [DATA_WIDTH-1:0] B_i,
   input  logic [REG_ADDR_W-1:0] rs1_i,
   input  logic [REG_ADDR_W-1:0] rs2_i,
   input  logic [REG_ADDR_W-1:0] rd_i,
   input  logic                  use_rs1_i,
   input  logic                  use_rs2_i,
   input  logic                  reg_write_i,
   input  logic                  flush_i,
   input  logic                  wb_we_i,
   input  logic [REG_ADDR_W-1:0] wb_rd_i,
   input  logic [DATA_WIDTH-1:0] wb_data_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [3:0]            ALU_Operation_o,
   output logic [DATA_WIDTH-1:0] A_o,
   output logic [DATA_WIDTH-1:0] B_o,
   output logic [REG_ADDR_W-1:0] rd_o,
   output logic                  reg_write_o
);

   typedef struct packed {
      logic [3:0]            op;
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic                  use_rs1;
      logic                  use_rs2;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
   } entry_t;

   state_t state;
   entry_t main_q, skid_q;
   entry_t in_p, in_f, main_f, skid_f;
   logic   in_fire, out_fire;

   assign in_p = '{op: ALU_Operation_i, a: A_i, b: B_i,
                   rs1: rs1_i, rs2: rs2_i,
                   use_rs1: use_rs1_i, use_rs2: use_rs2_i,
                   rd: rd_i, reg_write: reg_write_i};

`ifdef FORWARDING_EN
   logic [DATA_WIDTH-1:0] in_a, in_b, mn_a, mn_b, sk_a, sk_b;

   id_ex_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_in_a (
      .wb_we(wb_we_i), .wb_rd(wb_rd_i), .wb_data(wb_data_i),
      .rs(in_p.rs1), .use_rs(in_p.use_rs1), .operand(in_p.a), .result(in_a));
   id_ex_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_in_b (
      .wb_we(wb_we_i), .wb_rd(wb_rd_i), .wb_data(wb_data_i),
      .rs(in_p.rs2), .use_rs(in_p.use_rs2), .operand(in_p.b), .result(in_b));
   id_ex_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_mn_a (
      .wb_we(wb_we_i), .wb_rd(wb_rd_i), .wb_data(wb_data_i),
      .rs(main_q.rs1), .use_rs(main_q.use_rs1), .operand(main_q.a), .result(mn_a));
   id_ex_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_mn_b (
      .wb_we(wb_we_i), .wb_rd(wb_rd_i), .wb_data(wb_data_i),
      .rs(main_q.rs2), .use_rs(main_q.use_rs2), .operand(main_q.b), .result(mn_b));
   id_ex_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_sk_a (
      .wb_we(wb_we_i), .wb_rd(wb_rd_i), .wb_data(wb_data_i),
      .rs(skid_q.rs1), .use_rs(skid_q.use_rs1), .operand(skid_q.a), .result(sk_a));
   id_ex_fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_sk_b (
      .wb_we(wb_we_i), .wb_rd(wb_rd_i), .wb_data(wb_data_i),
      .rs(skid_q.rs2), .use_rs(skid_q.use_rs2), .operand(skid_q.b), .result(sk_b));

   always_comb begin
      in_f     = in_p;
      in_f.a   = in_a;
      in_f.b   = in_b;
      main_f   = main_q;
      main_f.a = mn_a;
      main_f.b = mn_b;
      skid_f   = skid_q;
      skid_f.a = sk_a;
      skid_f.b = sk_b;
   end
`else
   logic unused_wb;

   assign in_f      = in_p;
   assign main_f    = main_q;
   assign skid_f    = skid_q;
   assign unused_wb = ^{wb_we_i, wb_rd_i, wb_data_i};
`endif

   assign in_fire  = valid_i && ready_o;
   assign out_fire = valid_o && ready_i;

   // Held entries are rewritten every cycle so forwarded values stick.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_o <= 1'b1;
      end else if (flush_i) begin
         state   <= EMPTY;
         ready_o <= 1'b1;
      end else begin
         main_q <= main_f;
         skid_q <= skid_f;
         unique case (state)
            EMPTY: begin
               if (in_fire) begin
                  main_q <= in_f;
                  state  <= ONE;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_q <= in_f;
               end else if (in_fire) begin
                  skid_q  <= in_f;
                  state   <= TWO;
                  ready_o <= 1'b0;
               end else if (out_fire) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               if (out_fire) begin
                  main_q  <= skid_f;
                  state   <= ONE;
                  ready_o <= 1'b1;
               end
            end
            default: begin
               state   <= EMPTY;
               ready_o <= 1'b1;
            end
         endcase
      end
   end

   assign valid_o         = (state != EMPTY);
   assign ALU_Operation_o = main_q.op;
   assign A_o             = main_q.a;
   assign B_o             = main_q.b;
   assign rd_o            = main_q.rd;
   assign reg_write_o     = main_q.reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, backpressure, streaming,
// flush, immediate operands and (with FORWARDING_EN) forwarding.
module tb_id_ex_stage;
   import id_ex_pkg::*;

   localparam int DW = 32;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          valid_i, ready_o, valid_o, ready_i, flush_i;
   logic [3:0]    ALU_Operation_i, ALU_Operation_o;
   logic [DW-1:0] A_i, B_i, A_o, B_o, wb_data_i;
   logic [RW-1:0] rs1_i, rs2_i, rd_i, rd_o, wb_rd_i;
   logic          use_rs1_i, use_rs2_i, reg_write_i, reg_write_o, wb_we_i;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_W(RW)) dut (
      .clk(clk), .reset(reset),
      .valid_i(valid_i), .ready_o(ready_o),
      .ALU_Operation_i(ALU_Operation_i), .A_i(A_i), .B_i(B_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
      .use_rs1_i(use_rs1_i), .use_rs2_i(use_rs2_i),
      .reg_write_i(reg_write_i), .flush_i(flush_i),
      .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .valid_o(valid_o), .ready_i(ready_i),
      .ALU_Operation_o(ALU_Operation_o), .A_o(A_o), .B_o(B_o),
      .rd_o(rd_o), .reg_write_o(reg_write_o)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      valid_i = 0; flush_i = 0; wb_we_i = 0; wb_rd_i = '0; wb_data_i = '0;
      ALU_Operation_i = ALU_ADD; A_i = '0; B_i = '0;
      rs1_i = '0; rs2_i = '0; rd_i = '0;
      use_rs1_i = 0; use_rs2_i = 0; reg_write_i = 0;
   endtask

   task automatic drain();
      idle();
      ready_i = 1;
      repeat (3) step();
   endtask

   task automatic test_reset();
      idle();
      ready_i = 0; valid_i = 1; A_i = 32'h77; B_i = 32'h88;
      ALU_Operation_i = ALU_ORI; rd_i = 5'd3; reg_write_i = 1;
      reset = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if ({valid_o, ready_o, A_o, B_o, ALU_Operation_o, rd_o, reg_write_o}
             !== {1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 5'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_hold v=%b r=%b A=%h op=%h rd=%h expected v=0 r=1 A=0 op=0 rd=0",
                     valid_o, ready_o, A_o, ALU_Operation_o, rd_o);
         end
      end
      @(negedge clk);
      reset = 1;
      valid_i = 0;
      step();
      step();
      n_cmp++;
      if ({valid_o, ready_o} !== 2'b01) begin
         n_bad++;
         $display("FAIL reset_release v=%b r=%b expected v=0 r=1", valid_o, ready_o);
      end
   endtask

   task automatic test_reset_mid();
      idle();
      ready_i = 0; valid_i = 1; A_i = 32'hA1;
      step();
      A_i = 32'hA2;
      step();
      @(negedge clk);
      reset = 0;
      #1;
      n_cmp++;
      if ({valid_o, ready_o, A_o} !== {1'b0, 1'b1, 32'h0}) begin
         n_bad++;
         $display("FAIL reset_async v=%b r=%b A=%h expected v=0 r=1 A=0",
                  valid_o, ready_o, A_o);
      end
      @(negedge clk);
      reset = 1;
      valid_i = 0;
      ready_i = 1;
      step();
      n_cmp++;
      if (valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid_after v=%b expected 0", valid_o);
      end
   endtask

   task automatic test_backpressure();
      idle();
      ready_i = 0; valid_i = 1; A_i = 32'd1;
      step();
      n_cmp++;
      if ({valid_o, ready_o, A_o} !== {1'b1, 1'b1, 32'd1}) begin
         n_bad++;
         $display("FAIL bp_one v=%b r=%b A=%h expected v=1 r=1 A=1", valid_o, ready_o, A_o);
      end
      A_i = 32'd2;
      step();
      n_cmp++;
      if ({valid_o, ready_o, A_o} !== {1'b1, 1'b0, 32'd1}) begin
         n_bad++;
         $display("FAIL bp_two v=%b r=%b A=%h expected v=1 r=0 A=1", valid_o, ready_o, A_o);
      end
      A_i = 32'd3;
      step();
      n_cmp++;
      if ({valid_o, ready_o, A_o} !== {1'b1, 1'b0, 32'd1}) begin
         n_bad++;
         $display("FAIL bp_stall v=%b r=%b A=%h expected v=1 r=0 A=1", valid_o, ready_o, A_o);
      end
      ready_i = 1;
      step();
      n_cmp++;
      if ({valid_o, ready_o, A_o} !== {1'b1, 1'b1, 32'd2}) begin
         n_bad++;
         $display("FAIL bp_out2 v=%b r=%b A=%h expected v=1 r=1 A=2", valid_o, ready_o, A_o);
      end
      step();
      valid_i = 0;
      n_cmp++;
      if ({valid_o, A_o} !== {1'b1, 32'd3}) begin
         n_bad++;
         $display("FAIL bp_out3 v=%b A=%h expected v=1 A=3", valid_o, A_o);
      end
      step();
      n_cmp++;
      if (valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_empty v=%b expected 0", valid_o);
      end
   endtask

   task automatic test_streaming();
      logic [31:0] v;
      idle();
      ready_i = 1;
      valid_i = 1;
      for (int i = 0; i < 10; i++) begin
         v = i;
         A_i = v;
         rd_i = v[4:0] + 5'd1;
         reg_write_i = v[0];
         step();
         n_cmp++;
         if ({valid_o, ready_o, A_o, rd_o, reg_write_o}
             !== {1'b1, 1'b1, v, v[4:0] + 5'd1, v[0]}) begin
            n_bad++;
            $display("FAIL stream_%0d v=%b r=%b A=%h rd=%h expected v=1 r=1 A=%h rd=%h",
                     i, valid_o, ready_o, A_o, rd_o, v, v[4:0] + 5'd1);
         end
      end
      valid_i = 0;
      step();
      n_cmp++;
      if (valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL stream_end v=%b expected 0", valid_o);
      end
   endtask

   task automatic test_flush();
      idle();
      ready_i = 0; valid_i = 1; A_i = 32'h11;
      step();
      A_i = 32'h22;
      step();
      flush_i = 1;
      A_i = 32'h55;
      step();
      flush_i = 0;
      valid_i = 0;
      n_cmp++;
      if ({valid_o, ready_o} !== 2'b01) begin
         n_bad++;
         $display("FAIL flush_two v=%b r=%b expected v=0 r=1", valid_o, ready_o);
      end
      ready_i = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (valid_o !== 1'b0 || A_o === 32'h55) begin
            n_bad++;
            $display("FAIL flush_quiet v=%b A=%h expected v=0 A!=55", valid_o, A_o);
         end
      end
      ready_i = 0; valid_i = 1; A_i = 32'h33;
      step();
      flush_i = 1; ready_i = 1; A_i = 32'h66;
      step();
      flush_i = 0;
      valid_i = 0;
      n_cmp++;
      if ({valid_o, ready_o} !== 2'b01) begin
         n_bad++;
         $display("FAIL flush_one v=%b r=%b expected v=0 r=1", valid_o, ready_o);
      end
      step();
      n_cmp++;
      if (valid_o !== 1'b0 || A_o === 32'h66) begin
         n_bad++;
         $display("FAIL flush_drop v=%b A=%h expected v=0 A!=66", valid_o, A_o);
      end
   endtask

`ifdef FORWARDING_EN
   task automatic test_forwarding();
      drain();
      ready_i = 0; valid_i = 1; A_i = 32'h10; rs1_i = 5'd5; use_rs1_i = 1;
      step();
      valid_i = 0;
      wb_we_i = 1; wb_rd_i = 5'd5; wb_data_i = 32'hABCD;
      step();
      wb_we_i = 0;
      n_cmp++;
      if (A_o !== 32'hABCD) begin
         n_bad++;
         $display("FAIL fwd_hit A=%h expected ABCD", A_o);
      end
      drain();
      ready_i = 0; valid_i = 1; A_i = 32'h10; rs1_i = 5'd0; use_rs1_i = 1;
      step();
      valid_i = 0;
      wb_we_i = 1; wb_rd_i = 5'd0; wb_data_i = 32'hABCD;
      step();
      wb_we_i = 0;
      n_cmp++;
      if (A_o !== 32'h10) begin
         n_bad++;
         $display("FAIL fwd_x0 A=%h expected 10", A_o);
      end
      drain();
   endtask
`endif

   task automatic test_immediate();
      drain();
      ready_i = 0; valid_i = 1;
      ALU_Operation_i = ALU_LUI; use_rs2_i = 0; rs2_i = 5'd5; B_i = 32'h12345;
      wb_we_i = 1; wb_rd_i = 5'd5; wb_data_i = 32'hDEAD;
      step();
      valid_i = 0;
      step();
      n_cmp++;
      if ({ALU_Operation_o, B_o} !== {ALU_LUI, 32'h12345}) begin
         n_bad++;
         $display("FAIL imm_lui op=%h B=%h expected op=%h B=12345",
                  ALU_Operation_o, B_o, ALU_LUI);
      end
      drain();
   endtask

   initial begin
      ready_i = 0;
      idle();
      test_reset();
      test_reset_mid();
      drain();
      test_backpressure();
      test_streaming();
      test_flush();
`ifdef FORWARDING_EN
      test_forwarding();
`endif
      test_immediate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set width of A/B operand and write-back data paths.
REQ-002 Parameter REG_ADDR_W, default 5, SHALL set width of rs1/rs2/rd register indices.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 reset  in  1  SHALL be asynchronous, active-low reset (0 = reset asserted).
REQ-005 valid_i / ready_o  in/out  1  SHALL be the upstream (decode) handshake; transfer when both high at a rising edge.
REQ-006 ALU_Operation_i  in  4, A_i/B_i  in  DATA_WIDTH, rs1_i/rs2_i/rd_i  in  REG_ADDR_W, use_rs1_i/use_rs2_i/reg_write_i  in  1  SHALL form the captured payload.
REQ-007 flush_i  in  1  SHALL discard all held entries (branch/jump redirect).
REQ-008 wb_we_i  in  1, wb_rd_i  in  REG_ADDR_W, wb_data_i  in  DATA_WIDTH  SHALL be the write-back port used for forwarding.
REQ-009 valid_o / ready_i  out/in  1  SHALL be the downstream (ALU/EX) handshake.
REQ-010 ALU_Operation_o  out  4, A_o/B_o  out  DATA_WIDTH, rd_o  out  REG_ADDR_W, reg_write_o  out  1  SHALL present the head entry to the ALU.

Function
REQ-011 Block SHALL be a two-entry skid buffer (main + skid) with states EMPTY, ONE, TWO.
REQ-012 ready_o SHALL be registered and equal 1 in EMPTY and ONE, 0 in TWO; no combinational path from ready_i to ready_o.
REQ-013 valid_o SHALL be 1 in ONE and TWO; outputs SHALL always reflect the main entry.
REQ-014 Transitions: EMPTY+in -> ONE; ONE+in+out -> ONE (main replaced); ONE+in, no out -> TWO (input to skid); ONE+out, no in -> EMPTY; TWO+out -> ONE (skid moves to main); otherwise hold.
REQ-015 Latency SHALL be one cycle: payload accepted at edge N appears on outputs after edge N when main was empty or being drained.
REQ-016 Ordering SHALL be strict FIFO; no entry dropped or duplicated except by flush.
REQ-017 Outputs SHALL remain stable while valid_o=1 and ready_i=0.
REQ-018 flush_i=1 at an edge SHALL force EMPTY, valid_o=0, ready_o=1 next cycle; flush overrides a simultaneous upstream transfer (input dropped) and downstream transfer.
REQ-019 Held payload fields SHALL be registered unmodified except as in REQ-022; no arithmetic on A/B.

Reset
REQ-020 reset=0 SHALL immediately force EMPTY, valid_o=0, ready_o=1, ALU_Operation_o=4'b0000 (ADD), A_o=B_o=0, rd_o=0, reg_write_o=0, skid cleared.
REQ-021 Reset asserted mid-transfer SHALL discard all entries; first post-reset transfer requires a fresh valid_i.

Configuration
REQ-022 With FORWARDING_EN defined: when wb_we_i=1, wb_rd_i!=0, and wb_rd_i matches rs1 (use_rs1=1) or rs2 (use_rs2=1) of the incoming payload or any held entry, that operand SHALL be replaced by wb_data_i on the same edge; rd=0 never forwards; use_rs2=0 (immediate/LUI) never forwards B.
REQ-023 Without FORWARDING_EN: wb_* ports SHALL exist and be ignored; rs1/rs2/use_rs* need not be stored.

Structure
REQ-024 State encoding (EMPTY/ONE/TWO) and ALU opcode constants (ADD=4'b0000, LUI=4'b1000, ORI=4'b1001) SHALL live in a shared package used by the ALU and this block.
REQ-025 One sub-module, id_ex_fwd_mux, SHALL implement per-operand forwarding compare/select; instantiated only under FORWARDING_EN.

Verification
REQ-026 Reset: reset=0 with valid_i=1 -> valid_o=0, ready_o=1, A_o=0, ALU_Operation_o=0 throughout; after release, no output until new transfer.
REQ-027 Backpressure: push ops A_i=1,2,3 with ready_i=0 -> accept 1,2 then ready_o=0; raise ready_i -> outputs 1,2,3 in order, one per cycle.
REQ-028 Streaming: valid_i=ready_i=1 for 10 cycles, A_i=0..9 -> A_o=0..9 one cycle delayed, ready_o never drops.
REQ-029 Flush: state TWO, flush_i=1 with valid_i=1 (A_i=0x55) -> next cycle valid_o=0, 0x55 never appears.
REQ-030 Forwarding (FORWARDING_EN): held entry rs1=5, use_rs1=1, A=0x10, ready_i=0; wb_we_i=1, wb_rd_i=5, wb_data_i=0xABCD -> A_o=0xABCD next cycle; repeat with wb_rd_i=0 -> A_o unchanged.
REQ-031 Immediate: ALU_Operation_i=LUI, use_rs2_i=0, rs2_i=5, B_i=0x12345, wb_rd_i=5 -> B_o=0x12345.
